// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared constants and IF/ID record for the pipelined RISC-V core
package core_pkg;

    localparam int XLEN = 32;
    localparam int ADDR_WIDTH_DEFAULT = XLEN;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
        logic            misaligned;
    } if_id_t;

    // A bubble carries the NOP encoding and zeroes every other field.
    function automatic if_id_t if_id_bubble(input logic [31:0] nop);
        if_id_t b;
        b       = '0;
        b.instr = nop;
        return b;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id.sv
// rtl/instruction_fetch_stage_if_id.sv - IF/ID pipeline register with stall, flush and bubble handling
module if_id_register
    import core_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   stall_i,
    input  logic   flush_i,
    input  if_id_t fetch_i,
    output if_id_t if_id_o,
    output logic   load_o
);

    if_id_t if_id_q;
    if_id_t if_id_d;

    // Flush beats stall so a killed wrong-path fetch never lingers in decode.
    always_comb begin
        if_id_d = if_id_q;
        load_o  = 1'b0;
        if (flush_i) begin
            if_id_d = if_id_bubble(NOP_INSTR);
        end else if (!stall_i) begin
            if_id_d = fetch_i;
            load_o  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= if_id_bubble(NOP_INSTR);
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign if_id_o = if_id_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - PC register, IF/ID latch and retired-fetch counter
module instruction_fetch_stage
    import core_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0]           NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_f,
    input  logic                  stall_d,
    input  logic                  flush_d,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    output logic [ADDR_WIDTH-1:0] pc_f,
    output logic [31:0]           instr_d,
    output logic [ADDR_WIDTH-1:0] pc_d,
    output logic [ADDR_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic                  misaligned_d,
    output logic [31:0]           fetch_count
);

    logic [ADDR_WIDTH-1:0] pc_f_q;
    logic [ADDR_WIDTH-1:0] pc_f_d;
    logic [ADDR_WIDTH-1:0] pc_plus4_f;
    logic [31:0]           fetch_count_q;
    logic [31:0]           fetch_count_d;
    if_id_t                fetch_rec;
    if_id_t                if_id_rec;
    logic                  if_id_load;

    assign pc_plus4_f = pc_f_q + ADDR_WIDTH'(4);

    // Redirect outranks stall_f so a taken branch is never dropped while fetch is held.
    always_comb begin
        pc_f_d = pc_plus4_f;
        if (redirect) begin
            pc_f_d = redirect_target;
        end else if (stall_f) begin
            pc_f_d = pc_f_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q <= RESET_PC;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    always_comb begin
        fetch_rec            = '0;
        fetch_rec.instr      = imem_data;
        fetch_rec.pc         = XLEN'(pc_f_q);
        fetch_rec.pc_plus4   = XLEN'(pc_plus4_f);
        fetch_rec.valid      = 1'b1;
        fetch_rec.misaligned = |pc_f_q[1:0];
    end

    if_id_register #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst     (rst),
        .stall_i (stall_d),
        .flush_i (flush_d),
        .fetch_i (fetch_rec),
        .if_id_o (if_id_rec),
        .load_o  (if_id_load)
    );

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (if_id_load) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr    = pc_f_q;
    assign pc_f         = pc_f_q;
    assign instr_d      = if_id_rec.instr;
    assign pc_d         = if_id_rec.pc[ADDR_WIDTH-1:0];
    assign pc_plus4_d   = if_id_rec.pc_plus4[ADDR_WIDTH-1:0];
    assign valid_d      = if_id_rec.valid;
    assign misaligned_d = if_id_rec.misaligned;
    assign fetch_count  = fetch_count_q;

endmodule
